// File: rtl/apb_cmd_master.sv
// Turns a valid/ready command stream into single APB transfers and returns the result on a
// valid/ready response channel. Transfers that see no pready within TIMEOUT ACCESS cycles are aborted.
module apb_cmd_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic        cmd_write,
  input  logic [3:0]  cmd_strb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_slverr,
  output logic        rsp_timeout,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [3:0]  pstrb,
  input  logic        pready,
  input  logic        pslverr,
  input  logic [31:0] prdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam int              CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W:0]  TO_VAL = (CNT_W + 1)'(TIMEOUT);

  logic [1:0]       state_q,       state_d;
  logic             cmd_ready_q,   cmd_ready_d;
  logic             rsp_valid_q,   rsp_valid_d;
  logic [31:0]      rsp_rdata_q,   rsp_rdata_d;
  logic             rsp_slverr_q,  rsp_slverr_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic [31:0]      paddr_q,       paddr_d;
  logic [31:0]      pwdata_q,      pwdata_d;
  logic             psel_q,        psel_d;
  logic             penable_q,     penable_d;
  logic             pwrite_q,      pwrite_d;
  logic [3:0]       pstrb_q,       pstrb_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic [CNT_W:0]   cnt_inc;

  // One bit wider than the counter so the compare against TIMEOUT cannot wrap.
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case can leave a latch behind.
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    pstrb_d       = pstrb_q;
    cnt_d         = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d     = S_SETUP;
          cmd_ready_d = 1'b0;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
          pwrite_d    = cmd_write;
          pstrb_d     = cmd_write ? cmd_strb : 4'b0000;
          psel_d      = 1'b1;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      S_ACCESS: begin
        if (pready) begin
          state_d       = S_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? 32'h0 : prdata;
          rsp_slverr_d  = pslverr;
          rsp_timeout_d = 1'b0;
        end else if ((TIMEOUT != 0) && (cnt_inc == TO_VAL)) begin
          state_d       = S_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = 32'h0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      default: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pstrb_q       <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      pstrb_q       <= pstrb_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign pstrb       = pstrb_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: stimulus pushes expected responses into a queue,
// a monitor pops and compares on every response handshake; cycle-level checks run inline.
module tb_apb_cmd_master;

  typedef struct packed {
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  pstrb;
  logic        pready = 1'b1;
  logic        pslverr = 1'b0;
  logic [31:0] prdata = '0;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  apb_cmd_master #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_write(cmd_write), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwdata(pwdata), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pstrb(pstrb), .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for cmd_ready, presents one command for exactly the accepting edge, returns in SETUP.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic w,
                       input logic [3:0] s, input logic [31:0] e_rdata,
                       input logic e_slverr, input logic e_timeout);
    int n = 0;
    exp_t e;
    step();
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    check("issue_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_write = w;
    cmd_strb  = s;
    e.rdata   = e_rdata;
    e.slverr  = e_slverr;
    e.timeout = e_timeout;
    exp_q.push_back(e);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      step();
      n++;
    end
    check("rsp_drain", exp_q.size(), 32'd0);
    step();
  endtask

  // Response monitor: compares on every accepted response.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h with no expected response queued", rsp_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_slverr", {31'b0, rsp_slverr}, {31'b0, e.slverr});
        check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e.timeout});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("rst_psel", {31'b0, psel}, 32'd0);
    check("rst_penable", {31'b0, penable}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_paddr", paddr, 32'd0);
    rst = 1'b0;
    step();
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Zero-wait read: psel N+1, penable N+2, rsp_valid N+3
    pready = 1'b1; pslverr = 1'b0; prdata = 32'hDEADBEEF; rsp_ready = 1'b1;
    issue(32'h100, 32'h0, 1'b0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
    check("rd_setup_psel", {31'b0, psel}, 32'd1);
    check("rd_setup_penable", {31'b0, penable}, 32'd0);
    check("rd_setup_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rd_pstrb_zero", {28'b0, pstrb}, 32'd0);
    step();
    check("rd_access_penable", {31'b0, penable}, 32'd1);
    check("rd_access_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    step();
    check("rd_resp_valid", {31'b0, rsp_valid}, 32'd1);
    check("rd_resp_psel", {31'b0, psel}, 32'd0);
    wait_drain();
    check("rd_idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Write with 3 wait states; pready arrives as the counter reaches TIMEOUT, so it completes
    pready = 1'b0;
    issue(32'h40, 32'h12345678, 1'b1, 4'hF, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      if (i == 4) pready = 1'b1;
      check("wr_paddr", paddr, 32'h40);
      check("wr_pwdata", pwdata, 32'h12345678);
      check("wr_pstrb", {28'b0, pstrb}, 32'hF);
      check("wr_pwrite", {31'b0, pwrite}, 32'd1);
      check("wr_psel", {31'b0, psel}, 32'd1);
      check("wr_penable", {31'b0, penable}, (i > 0) ? 32'd1 : 32'd0);
      check("wr_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    step();
    check("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    wait_drain();

    // Slave error on read
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFE0001;
    issue(32'h104, 32'h0, 1'b0, 4'h5, 32'hCAFE0001, 1'b1, 1'b0);
    wait_drain();
    pslverr = 1'b0;

    // Timeout: four ACCESS cycles without pready, then abort
    pready = 1'b0; prdata = 32'h55555555;
    issue(32'h200, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("to_penable", {31'b0, penable}, 32'd1);
      check("to_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    step();
    check("to_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("to_psel_low", {31'b0, psel}, 32'd0);
    wait_drain();

    // Backpressure: response held, new commands ignored
    pready = 1'b1; prdata = 32'h0BADF00D; rsp_ready = 1'b0;
    issue(32'h300, 32'h0, 1'b0, 4'h0, 32'h0BADF00D, 1'b0, 1'b0);
    step();
    step();
    prdata = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_addr  = 32'h999;
      check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'h0BADF00D);
      check("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("bp_psel", {31'b0, psel}, 32'd0);
      check("bp_paddr", paddr, 32'h300);
      step();
    end
    cmd_valid = 1'b0;
    check("bp_paddr_after", paddr, 32'h300);
    rsp_ready = 1'b1;
    wait_drain();
    check("bp_cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
    check("bp_no_spurious_psel", {31'b0, psel}, 32'd0);

    // Reset in the middle of ACCESS
    pready = 1'b0;
    issue(32'h500, 32'hA5A5A5A5, 1'b1, 4'h3, 32'h0, 1'b0, 1'b0);
    step();
    check("mr_access_penable", {31'b0, penable}, 32'd1);
    rst = 1'b1;
    step();
    exp_q.delete();
    check("mr_psel", {31'b0, psel}, 32'd0);
    check("mr_penable", {31'b0, penable}, 32'd0);
    check("mr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mr_paddr", paddr, 32'd0);
    check("mr_pwdata", pwdata, 32'd0);
    check("mr_pstrb", {28'b0, pstrb}, 32'd0);
    check("mr_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    step();
    check("mr_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Normal write after reset recovery
    pready = 1'b1;
    issue(32'h600, 32'h87654321, 1'b1, 4'h9, 32'h0, 1'b0, 1'b0);
    check("post_pstrb", {28'b0, pstrb}, 32'h9);
    check("post_pwdata", pwdata, 32'h87654321);
    wait_drain();
    check("post_idle_paddr", paddr, 32'h600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, ACCESS-phase cycles without pready before abort (0 = timeout disabled).
REQ-002 SHALL have ports (name direction width meaning):
  clk  input  1  single clock, all state on rising edge
  rst  input  1  synchronous, active-high reset
  cmd_valid  input  1  command request
  cmd_ready  output  1  command accepted when valid&&ready
  cmd_addr  input  32  transfer address
  cmd_wdata  input  32  write data
  cmd_write  input  1  1=write, 0=read
  cmd_strb  input  4  write byte strobes
  rsp_valid  output  1  response available
  rsp_ready  input  1  response consumed when valid&&ready
  rsp_rdata  output  32  read data (0 for writes/aborts)
  rsp_slverr  output  1  slave error or timeout
  rsp_timeout  output  1  transfer aborted by timeout
  paddr  output  32  APB address
  pwdata  output  32  APB write data
  psel  output  1  APB select
  penable  output  1  APB enable
  pwrite  output  1  APB direction
  pstrb  output  4  APB strobes
  pready  input  1  APB ready
  pslverr  input  1  APB error
  prdata  input  32  APB read data
REQ-003 Clock and reset SHALL be one clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; all outputs driven from registers.
REQ-005 cmd_ready SHALL be 1 only in IDLE; IDLE->SETUP on cmd_valid, latching addr/wdata/write/strb.
REQ-006 pstrb SHALL be latched cmd_strb for writes, 4'b0000 for reads.
REQ-007 SETUP: psel=1, penable=0; unconditional SETUP->ACCESS next cycle.
REQ-008 ACCESS: psel=1, penable=1; paddr/pwdata/pwrite/pstrb SHALL stay stable from SETUP until exit.
REQ-009 ACCESS with pready=1: rsp_rdata<=prdata (reads) or 0 (writes), rsp_slverr<=pslverr, rsp_timeout<=0; go RESP, psel/penable=0 next cycle.
REQ-010 Timeout counter SHALL clear on SETUP and increment each ACCESS cycle with pready=0; when TIMEOUT!=0 and count reaches TIMEOUT with pready still 0, abort: rsp_rdata=0, rsp_slverr=1, rsp_timeout=1, go RESP.
REQ-011 pready=1 on the same cycle the counter reaches TIMEOUT SHALL complete normally (pready wins).
REQ-012 RESP: rsp_valid=1, response fields held stable until rsp_ready=1; then IDLE, rsp_valid=0.
REQ-013 Latency: command accepted cycle N -> SETUP N+1 -> ACCESS N+2 -> rsp_valid N+3 for zero-wait slave; max throughput one transfer per 4 cycles.
REQ-014 Address/data registers SHALL retain last transfer value in IDLE; psel/penable SHALL be 0 in IDLE and RESP.
REQ-015 cmd_valid in non-IDLE states SHALL be ignored (no acceptance, no state corruption).

Reset
REQ-016 rst=1 SHALL force IDLE from any state (including mid-ACCESS) and clear psel, penable, rsp_valid, rsp_slverr, rsp_timeout, counter, paddr, pwdata, pwrite, pstrb, rsp_rdata to 0; cmd_ready=1 the cycle after rst deasserts.

Verification
REQ-017 Read, zero-wait: cmd addr=0x100 write=0, pready=1, prdata=0xDEADBEEF -> psel rise N+1, penable N+2, rsp_valid N+3 with rdata=0xDEADBEEF, slverr=0.
REQ-018 Write, 3 wait states: addr=0x40 wdata=0x12345678 strb=0xF -> paddr/pwdata/pstrb stable 5 cycles, rsp_rdata=0, slverr=0.
REQ-019 Slave error: pready=1 pslverr=1 on read -> rsp_slverr=1, rsp_timeout=0.
REQ-020 Timeout: TIMEOUT=4, pready held 0 -> abort after 4 ACCESS cycles, rsp_slverr=1, rsp_timeout=1, rdata=0; with pready on 4th cycle -> normal completion.
REQ-021 Backpressure: rsp_ready=0 for 5 cycles -> rsp fields stable, cmd_ready=0 throughout, new cmd_valid ignored.
REQ-022 Reset mid-ACCESS: rst=1 during ACCESS -> next cycle psel=0, penable=0, rsp_valid=0, state IDLE.
